// File: rtl/lamp_timer_ctrl.sv
// Timed stairwell lamp controller with blinking warning phase and hold override.
// Optional macro BUZZER_WARN_EN drives an active-low buzzer in step with the WARN blink.
module lamp_timer_ctrl #(
    parameter int unsigned N_SW       = 3,
    parameter int unsigned CNT_W      = 28,
    parameter int unsigned ON_TICKS   = 32'h0FFF_FFFF,
    parameter int unsigned WARN_TICKS = 32'h03FF_FFFF,
    parameter int unsigned BLINK_SH   = 22
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw,
    input  logic            hold,
    output logic            lamp_n,
    output logic            buzzer_n,
    output logic [1:0]      state_o
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_WARN = 2'd2;

    localparam bit             HAS_WARN  = (WARN_TICKS > 0);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] WARN_LAST = CNT_W'(HAS_WARN ? WARN_TICKS - 1 : 0);

    logic [N_SW-1:0]  sw_s1;
    logic [N_SW-1:0]  sw_s2;
    logic             par_q;
    logic             toggle;
    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;

    // Reset preloads the synchroniser with the live switch levels so release makes no toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= sw;
            sw_s2 <= sw;
            par_q <= ^sw;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            par_q <= ^sw_s2;
        end
    end

    assign toggle = (^sw_s2) ^ par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OFF;
            count <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
        end
    end

    // Terminal compare precedes increment, so count never wraps.
    always_comb begin
        state_d = ST_OFF;
        count_d = '0;
        if (hold || toggle) begin
            state_d = ST_ON;
        end else begin
            case (state)
                ST_ON: begin
                    if (count == ON_LAST) begin
                        state_d = HAS_WARN ? ST_WARN : ST_OFF;
                    end else begin
                        state_d = ST_ON;
                        count_d = count + 1'b1;
                    end
                end
                ST_WARN: begin
                    if (count == WARN_LAST) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_WARN;
                        count_d = count + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    always_comb begin
        lamp_n   = 1'b1;
        buzzer_n = 1'b1;
        case (state)
            ST_ON:   lamp_n = 1'b0;
            ST_WARN: begin
                lamp_n = count[BLINK_SH];
`ifdef BUZZER_WARN_EN
                buzzer_n = count[BLINK_SH];
`endif
            end
            default: lamp_n = 1'b1;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_lamp_timer_ctrl.sv
// Directed bench for lamp_timer_ctrl with short ON/WARN periods.
module tb_lamp_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sw;
    logic       hold;
    logic       lamp_n;
    logic       buzzer_n;
    logic [1:0] state_o;

    int checks   = 0;
    int failures = 0;

    lamp_timer_ctrl #(
        .N_SW(3), .CNT_W(8), .ON_TICKS(10), .WARN_TICKS(4), .BLINK_SH(1)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .hold(hold),
        .lamp_n(lamp_n), .buzzer_n(buzzer_n), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Buzzer expectation follows the lamp only while in WARN when the feature is built in.
    task automatic chk_out(input string tag, input logic [1:0] st, input logic lamp);
        logic buz;
        buz = 1'b1;
`ifdef BUZZER_WARN_EN
        if (st == 2'd2) buz = lamp;
`endif
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".lamp"}, 32'(lamp_n), 32'(lamp));
        chk({tag, ".buzz"}, 32'(buzzer_n), 32'(buz));
    endtask

    // Entered with state ON, count 0: rest of ON, WARN blink 0,0,1,1, then OFF.
    task automatic run_period(input string tag);
        logic [3:0] warn_lamp;
        warn_lamp = 4'b1100;
        for (int i = 1; i < 10; i++) begin
            tick();
            chk_out({tag, ".on"}, 2'd1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out({tag, ".warn"}, 2'd2, warn_lamp[i]);
        end
        tick();
        chk_out({tag, ".off"}, 2'd0, 1'b1);
    endtask

    initial begin
        rst  = 1'b1;
        sw   = 3'b101;
        hold = 1'b0;
        tick();
        tick();
        chk_out("reset", 2'd0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_out("idle", 2'd0, 1'b1);
        end

        // Single flip: lamp on at the third edge, then full period.
        sw[0] = ~sw[0];
        tick();
        chk_out("flip0.e0", 2'd0, 1'b1);
        tick();
        chk_out("flip0.e1", 2'd0, 1'b1);
        tick();
        chk_out("flip0.e2", 2'd1, 1'b0);
        run_period("p1");

        // Restart from WARN at count 2.
        sw[1] = ~sw[1];
        tick();
        tick();
        tick();
        chk_out("flip1.on", 2'd1, 1'b0);
        for (int i = 1; i < 10; i++) tick();
        tick();
        chk_out("restart.w0", 2'd2, 1'b0);
        sw[2] = ~sw[2];
        tick();
        chk_out("restart.w1", 2'd2, 1'b0);
        tick();
        chk_out("restart.w2", 2'd2, 1'b1);
        tick();
        chk_out("restart.on", 2'd1, 1'b0);
        run_period("p2");

        // Hold keeps lamp on; timeout runs only after release.
        hold = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk_out("hold", 2'd1, 1'b0);
        end
        hold = 1'b0;
        run_period("p3");

        // Even number of flips is invisible; odd number toggles.
        sw = sw ^ 3'b011;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("even", 2'd0, 1'b1);
        end
        sw = sw ^ 3'b111;
        tick();
        tick();
        chk_out("odd.e1", 2'd0, 1'b1);
        tick();
        chk_out("odd.e2", 2'd1, 1'b0);

        // Reset mid-WARN drops to OFF on that edge.
        for (int i = 1; i < 10; i++) tick();
        tick();
        chk_out("pre_rst.w0", 2'd2, 1'b0);
        tick();
        chk_out("pre_rst.w1", 2'd2, 1'b0);
        rst = 1'b1;
        tick();
        chk_out("rst_warn", 2'd0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("post_rst", 2'd0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
